uart_tx_arbiter: RTL

- Shares the single UART transmitter (driven by baud_1_x_p) between NUM_REQ_c independent byte producers, e.g. housekeeping telemetry, command echo and RX loopback.
- Round-robin grant, one byte per grant.
- Sequences the transmitter's req/done handshake so that no requester ever drives it directly.
- Sits between the payload logic and the UART transmitter, next to uart_rx and baud_generator.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rr_priority_select.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encodings, byte width, watchdog default
// and a small wrap-around increment helper.
package uart_pkg;

    localparam int          DATA_W_c         = 8;
    localparam logic [31:0] TIMEOUT_CYCLES_c = 32'd2_000_000;

    // 8 bits wide to line up with the existing UART state registers.
    typedef enum logic [7:0] {
        ARB_IDLE_c      = 8'd0,
        ARB_ISSUE_c     = 8'd1,
        ARB_WAIT_DONE_c = 8'd2,
        ARB_RELEASE_c   = 8'd3
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin selector: rotate the request vector so rr_ptr is bit 0, take the
// lowest set bit, rotate the result back. Purely combinational.
module rr_priority_select #(
    parameter int NUM_REQ_c = 4,
    parameter int IDX_W_c   = 2
) (
    input  logic [NUM_REQ_c-1:0] req_p,
    input  logic [IDX_W_c-1:0]   rr_ptr_p,
    output logic [NUM_REQ_c-1:0] grant_onehot_p,
    output logic [IDX_W_c-1:0]   grant_idx_p,
    output logic                 valid_p
);

    logic [NUM_REQ_c-1:0] w_rot;
    logic                 w_found;
    int                   w_pos;
    int                   w_src;
    int                   w_sum;

    always_comb begin
        w_rot   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_src   = 0;
        w_sum   = 0;
        for (int i = 0; i < NUM_REQ_c; i++) begin
            w_src = i + int'(rr_ptr_p);
            if (w_src >= NUM_REQ_c) w_src = w_src - NUM_REQ_c;
            w_rot[i] = req_p[w_src];
        end
        for (int i = 0; i < NUM_REQ_c; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_pos   = i;
            end
        end
        w_sum = w_pos + int'(rr_ptr_p);
        if (w_sum >= NUM_REQ_c) w_sum = w_sum - NUM_REQ_c;
        grant_idx_p    = IDX_W_c'(w_sum);
        grant_onehot_p = w_found ? (NUM_REQ_c'(1) << w_sum) : '0;
        valid_p        = w_found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter, one byte per grant.
// Optional watchdog on the transmitter handshake: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int          NUM_REQ_c        = 4,
    parameter int          DATA_W_c         = uart_pkg::DATA_W_c
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES_c = uart_pkg::TIMEOUT_CYCLES_c
`endif
) (
    input  logic                          clk210_p,
    input  logic                          reset_n_p,
    input  logic [NUM_REQ_c-1:0]          src_req_p,
    input  logic [NUM_REQ_c*DATA_W_c-1:0] src_data_p,
    output logic [NUM_REQ_c-1:0]          src_ack_p,
    output logic [NUM_REQ_c-1:0]          src_grant_p,
    output logic [DATA_W_c-1:0]           transmit_data_p,
    output logic                          transmit_req_p,
    input  logic                          transmit_done_p,
    output logic                          busy_p,
    output logic                          err_timeout_p,
    output logic [7:0]                    dbg_state_p
);
    import uart_pkg::*;

    localparam int IDX_W_c = $clog2(NUM_REQ_c);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic [IDX_W_c-1:0]   r_rr_ptr;
    logic [IDX_W_c-1:0]   r_owner;
    logic [NUM_REQ_c-1:0] r_grant;
    logic [DATA_W_c-1:0]  r_data;
    logic                 r_ack;
    logic [NUM_REQ_c-1:0] w_win_onehot;
    logic [IDX_W_c-1:0]   w_win_idx;
    logic                 w_any_req;
    logic                 w_timeout;

    rr_priority_select #(
        .NUM_REQ_c (NUM_REQ_c),
        .IDX_W_c   (IDX_W_c)
    ) u_rr_select (
        .req_p          (src_req_p),
        .rr_ptr_p       (r_rr_ptr),
        .grant_onehot_p (w_win_onehot),
        .grant_idx_p    (w_win_idx),
        .valid_p        (w_any_req)
    );

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            r_state  <= ARB_IDLE_c;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_data   <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= 1'b0;
            if (r_state == ARB_IDLE_c && w_any_req) begin
                r_owner <= w_win_idx;
                r_grant <= w_win_onehot;
                r_data  <= src_data_p[w_win_idx*DATA_W_c +: DATA_W_c];
            end
            // A watchdog abort still moves the pointer on so a dead byte cannot starve others.
            if (r_state == ARB_WAIT_DONE_c && (transmit_done_p || w_timeout)) begin
                r_rr_ptr <= IDX_W_c'(wrap_inc(int'(r_owner), NUM_REQ_c));
                r_ack    <= !w_timeout;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE_c:      if (w_any_req) w_next_state = ARB_ISSUE_c;
            ARB_ISSUE_c:     w_next_state = ARB_WAIT_DONE_c;
            ARB_WAIT_DONE_c: if (transmit_done_p) w_next_state = ARB_RELEASE_c;
            // Holding here until done falls keeps a stale done from finishing the next byte.
            ARB_RELEASE_c:   if (!transmit_done_p) w_next_state = ARB_IDLE_c;
            default:         w_next_state = ARB_IDLE_c;
        endcase
        if (w_timeout) w_next_state = ARB_IDLE_c;
    end

    always_comb begin
        transmit_req_p  = (r_state == ARB_WAIT_DONE_c);
        busy_p          = (r_state != ARB_IDLE_c);
        src_grant_p     = (r_state != ARB_IDLE_c) ? r_grant : '0;
        src_ack_p       = r_ack ? r_grant : '0;
        transmit_data_p = r_data;
        dbg_state_p     = r_state;
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [31:0] r_wd_cnt;
    logic        r_err_timeout;

    assign w_timeout = (r_state == ARB_WAIT_DONE_c || r_state == ARB_RELEASE_c) &&
                       (r_wd_cnt == TIMEOUT_CYCLES_c - 32'd1);
    assign err_timeout_p = r_err_timeout;

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_next_state == ARB_ISSUE_c) begin
                r_wd_cnt <= '0;
            end else if (r_state == ARB_WAIT_DONE_c || r_state == ARB_RELEASE_c) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
            if (w_timeout) r_err_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout     = 1'b0;
    assign err_timeout_p = 1'b0;
`endif

endmodule
